mux4_rr_arbiter: RTL

//  Shares one 4:1 datapath multiplexer between four requesters using round-robin arbitration.

---
 rtl/mux4_rr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 beat multiplexer between four valid/ready requesters,
// with packet locking and a single-entry registered output stage.
module mux4_rr_arbiter #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       req_valid_i,
  input  logic [3:0]       req_last_i,
  input  logic [Width-1:0] in1_i,
  input  logic [Width-1:0] in2_i,
  input  logic [Width-1:0] in3_i,
  input  logic [Width-1:0] in4_i,
  output logic [3:0]       req_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  output logic [1:0]       out_src_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic             lock_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_r, state_n_s;
  logic [1:0]       owner_r, owner_n_s;
  logic [1:0]       ptr_r, ptr_n_s;
  logic             space_s;
  logic             win_found_s;
  logic [1:0]       win_idx_s;
  logic             accept_s;
  logic [Width-1:0] win_data_s;

  // Returns {found, index} of the first valid requester scanning ptr, ptr+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    // Scan from the farthest offset down so the nearest valid requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx  = ptr + 2'(i);
      pick = valid[idx] ? {1'b1, idx} : pick;
    end
    return pick;
  endfunction

  // Winner selection and handshake; a locked owner is the only eligible requester.
  always_comb begin
    space_s     = !out_valid_o || out_ready_i;
    win_found_s = 1'b0;
    win_idx_s   = 2'd0;
    if (state_r == LOCKED) begin
      win_found_s = req_valid_i[owner_r];
      win_idx_s   = owner_r;
    end else begin
      {win_found_s, win_idx_s} = rr_pick(req_valid_i, ptr_r);
    end
    accept_s    = space_s && win_found_s;
    req_ready_o = accept_s ? (4'b0001 << win_idx_s) : 4'b0000;
  end

  // Shared datapath multiplexer.
  always_comb begin
    case (win_idx_s)
      2'd0:    win_data_s = in1_i;
      2'd1:    win_data_s = in2_i;
      2'd2:    win_data_s = in3_i;
      2'd3:    win_data_s = in4_i;
      default: win_data_s = in1_i;
    endcase
  end

  // Next-state logic: transitions happen only when a beat is accepted.
  always_comb begin
    state_n_s = state_r;
    owner_n_s = owner_r;
    ptr_n_s   = ptr_r;
    if (accept_s) begin
      if (req_last_i[win_idx_s]) begin
        state_n_s = IDLE;
        ptr_n_s   = win_idx_s + 2'd1;
      end else begin
        state_n_s = LOCKED;
        owner_n_s = win_idx_s;
      end
    end else begin
      state_n_s = state_r;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      owner_r <= 2'd0;
      ptr_r   <= 2'd0;
    end else begin
      state_r <= state_n_s;
      owner_r <= owner_n_s;
      ptr_r   <= ptr_n_s;
    end
  end

  // Single-entry output stage; an accept may coincide with the consumer's pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= 2'd0;
      out_last_o  <= 1'b0;
    end else if (accept_s) begin
      out_valid_o <= 1'b1;
      out_data_o  <= win_data_s;
      out_src_o   <= win_idx_s;
      out_last_o  <= req_last_i[win_idx_s];
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= out_valid_o;
    end
  end

  assign lock_o = (state_r == LOCKED);

endmodule
